data_memory_sized: RTL and testbench

- Parametrised, byte-addressed, little-endian data memory for the CPU load/store path.
- Supports byte, halfword and word accesses with sign or zero extension on loads.
- Uses a valid/ready request and a one-cycle response pulse with configurable wait states.
- One outstanding request; sits between the execute/mem stage and the memory array.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/data_memory_sized.sv | 158 +++++++++++++++
 tb/tb_data_memory_sized.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the sized data memory (data_memory_sized).
package dmem_pkg;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte-enables relative to the access address,
// store byte masking, load extraction with sign/zero extension, alignment flags.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rbytes_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wbytes_o,
  output logic [31:0] load_o,
  output logic        misaligned_o,
  output logic        reserved_o
);

  // Enables are per byte offset k from the access address, so rbytes/wbytes
  // byte k always maps to address+k (little-endian, wrap handled by the caller).
  always_comb begin
    byte_en_o    = 4'b0000;
    load_o       = '0;
    misaligned_o = 1'b0;
    reserved_o   = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        byte_en_o = 4'b0001;
        load_o    = {{24{~is_unsigned_i & rbytes_i[7]}}, rbytes_i[7:0]};
      end
      SZ_HALF: begin
        byte_en_o    = 4'b0011;
        load_o       = {{16{~is_unsigned_i & rbytes_i[15]}}, rbytes_i[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        byte_en_o    = 4'b1111;
        load_o       = rbytes_i;
        misaligned_o = |addr_lo_i;
      end
      default: reserved_o = 1'b1;
    endcase
  end

  assign wbytes_o = wdata_i & {{8{byte_en_o[3]}}, {8{byte_en_o[2]}},
                               {8{byte_en_o[1]}}, {8{byte_en_o[0]}}};

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory with valid/ready request and wait states.
// Build option DMEM_MISALIGN_FAULT_EN: misaligned half/word accesses fault instead of splitting.
//
// state | meaning
// IDLE  | ready; accepts a request and loads the wait counter
// WAIT  | counting wait states; array access happens on the edge leaving
// RESP  | one-cycle response pulse; incoming requests ignored
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        resp_valid,
  output logic [31:0] readData,
  output logic        fault
);

`ifdef DMEM_MISALIGN_FAULT_EN
  localparam bit MisalignFault = 1'b1;
`else
  localparam bit MisalignFault = 1'b0;
`endif
  localparam int LatEff = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam int Depth  = 1 << ADDR_BITS;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q, uns_q;
  size_e                  size_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            wdata_q, rdata_q;
  logic                   fault_q;
  logic [7:0]             mem_q [Depth];

  logic                   accept, commit, reject;
  logic                   cur_write, cur_uns;
  size_e                  cur_size;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic [31:0]            cur_wdata, rbytes, wbytes, load_val;
  logic [3:0]             byte_en;
  logic                   misaligned, reserved;
  logic                   unused_addr_hi;

  assign unused_addr_hi = ^address[31:ADDR_BITS];

  // With zero wait states the access commits on the accept edge, before the
  // request fields are latched, so the live inputs are used while in IDLE.
  assign cur_write = (state_q == IDLE) ? req_write : write_q;
  assign cur_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
  assign cur_size  = (state_q == IDLE) ? size_e'(req_size) : size_q;
  assign cur_addr  = (state_q == IDLE) ? address[ADDR_BITS-1:0] : addr_q;
  assign cur_wdata = (state_q == IDLE) ? writeData : wdata_q;

  always_comb begin
    rbytes = '0;
    for (int k = 0; k < 4; k++) begin
      rbytes[8*k +: 8] = mem_q[cur_addr + ADDR_BITS'(k)];
    end
  end

  dmem_lane_align u_align (
    .size_i        (cur_size),
    .addr_lo_i     (cur_addr[1:0]),
    .is_unsigned_i (cur_uns),
    .wdata_i       (cur_wdata),
    .rbytes_i      (rbytes),
    .byte_en_o     (byte_en),
    .wbytes_o      (wbytes),
    .load_o        (load_val),
    .misaligned_o  (misaligned),
    .reserved_o    (reserved)
  );

  assign reject = reserved | (MisalignFault & misaligned);
  assign accept = (state_q == IDLE) & req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = 4'(LatEff);
          if (LatEff == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
        addr_q  <= address[ADDR_BITS-1:0];
        wdata_q <= writeData;
      end
      if (commit) begin
        rdata_q <= (cur_write | reject) ? 32'd0 : load_val;
        fault_q <= reject;
      end
    end
  end

  // Array has no reset; a reset during WAIT/RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_write && !reject) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem_q[cur_addr + ADDR_BITS'(k)] <= wbytes[8*k +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE) & ~reset;
  assign resp_valid = (state_q == RESP);
  assign readData   = rdata_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: two instances (LATENCY 0 and 3), directed table,
// reset/throughput sequences and random traffic against a byte-array model.
module tb_data_memory_sized;

`ifdef DMEM_MISALIGN_FAULT_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset[2], req_valid[2], req_ready[2], req_write[2], req_unsigned[2];
  logic        resp_valid[2], fault[2];
  logic [1:0]  req_size[2];
  logic [31:0] address[2], writeData[2], readData[2];

  data_memory_sized #(.ADDR_BITS(16), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .address(address[0]), .writeData(writeData[0]), .resp_valid(resp_valid[0]),
    .readData(readData[0]), .fault(fault[0]));

  data_memory_sized #(.ADDR_BITS(16), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .address(address[1]), .writeData(writeData[1]), .resp_valid(resp_valid[1]),
    .readData(readData[1]), .fault(fault[1]));

  int lat_exp[2] = '{1, 4};
  logic [7:0] mdl [2][65536];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          d;
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          flt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: n bytes at (addr mod 64K)+k, little-endian, plain arithmetic.
  task automatic model_access(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output bit flt);
    int n;
    int base;
    logic [63:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    base = int'(addr & 32'h0000FFFF);
    rd = 32'd0;
    flt = 1'b0;
    if (n == 0 || (MIS && (base % n) != 0)) begin
      flt = 1'b1;
      return;
    end
    if (wr) begin
      for (int k = 0; k < n; k++) mdl[d][(base + k) % 65536] = wd[8*k +: 8];
    end else begin
      v = 64'd0;
      for (int k = 0; k < n; k++) v = v | (64'(mdl[d][(base + k) % 65536]) << (8 * k));
      if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      rd = v[31:0];
    end
  endtask

  task automatic txn(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input bit exp_flt, input string name);
    int n;
    int lat;
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "/ready"}, 32'(req_ready[d]), 32'd1);
    req_write[d] = wr; req_size[d] = sz; req_unsigned[d] = uns;
    address[d] = addr; writeData[d] = wd; req_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      if (req_ready[d] !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (req_ready[d] !== 1'b0) busy_ok = 1'b0;
    check({name, "/latency"}, 32'(lat), 32'(lat_exp[d]));
    check({name, "/readData"}, readData[d], exp_rd);
    check({name, "/fault"}, 32'(fault[d]), 32'(exp_flt));
    check({name, "/busy_not_ready"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({name, "/pulse_end"}, 32'(resp_valid[d]), 32'd0);
    check({name, "/readData_hold"}, readData[d], exp_rd);
    check({name, "/fault_hold"}, 32'(fault[d]), 32'(exp_flt));
  endtask

  task automatic mtxn(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd, input string name);
    logic [31:0] rd;
    bit flt;
    model_access(d, wr, sz, uns, addr, wd, rd, flt);
    txn(d, wr, sz, uns, addr, wd, rd, flt, name);
  endtask

  initial begin
    logic [31:0] rd;
    bit flt;
    int pulses;
    bit seen;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 65536; i++) mdl[d][i] = 8'h00;
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; address[d] = '0; writeData[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst/ready_low", 32'(req_ready[d]), 32'd0);
      check("rst/resp_valid", 32'(resp_valid[d]), 32'd0);
      check("rst/readData", readData[d], 32'd0);
      check("rst/fault", 32'(fault[d]), 32'd0);
      reset[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("rst/ready_after", 32'(req_ready[d]), 32'd1);

    // Clear every region the test touches so no result relies on power-up contents.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 'h60; a += 4) mtxn(d, 1'b1, 2'd2, 1'b0, 32'(a), 32'd0, "clr");
      for (int a = 'h100; a < 'h144; a += 4) mtxn(d, 1'b1, 2'd2, 1'b0, 32'(a), 32'd0, "clr");
      mtxn(d, 1'b1, 2'd2, 1'b0, 32'hFFF8, 32'd0, "clr");
      mtxn(d, 1'b1, 2'd2, 1'b0, 32'hFFFC, 32'd0, "clr");
    end

    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h10,   32'h0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h10,   32'h0, 32'h000000EF, 1'b0});
    tbl.push_back('{1, 1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b0, 2'd0, 1'b0, 32'h13,   32'h0, 32'hFFFFFFDE, 1'b0});
    tbl.push_back('{1, 1'b0, 2'd0, 1'b1, 32'h13,   32'h0, 32'h000000DE, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h22,   32'hFFFF1234, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h20,   32'h0, 32'h12340000, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h22,   32'h00008001, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b0, 32'h22,   32'h0, 32'hFFFF8001, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'hFFFF, 32'hA1B2C3D4, 32'h0, MIS});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'hFFFF, 32'h0, MIS ? 32'h0 : 32'hD4, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h0,    32'h0, MIS ? 32'h0 : 32'hC3, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h1,    32'h0, MIS ? 32'h0 : 32'hB2, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h2,    32'h0, MIS ? 32'h0 : 32'hA1, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'hFFFF, 32'h0, MIS ? 32'h0 : 32'hA1B2C3D4, MIS});
    tbl.push_back('{0, 1'b1, 2'd3, 1'b0, 32'h40,   32'hFFFFFFFF, 32'h0, 1'b1});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h40,   32'h0, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b1, 2'd1, 1'b0, 32'h31,   32'h0000BEEF, 32'h0, MIS});
    tbl.push_back('{1, 1'b0, 2'd2, 1'b0, 32'h30,   32'h0, MIS ? 32'h0 : 32'h00BEEF00, 1'b0});
    tbl.push_back('{1, 1'b0, 2'd0, 1'b0, 32'h32,   32'h0, MIS ? 32'h0 : 32'hFFFFFFBE, 1'b0});

    foreach (tbl[i]) begin
      model_access(tbl[i].d, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, rd, flt);
      txn(tbl[i].d, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
          tbl[i].rd, tbl[i].flt, $sformatf("tbl%0d", i));
    end

    // Reset while a store waits: nothing committed, no response.
    @(negedge clk);
    req_write[1] = 1'b1; req_size[1] = 2'd0; req_unsigned[1] = 1'b0;
    address[1] = 32'h50; writeData[1] = 32'h55; req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("midrst/in_wait", 32'(req_ready[1]), 32'd0);
    reset[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst/ready_low", 32'(req_ready[1]), 32'd0);
    check("midrst/resp_valid", 32'(resp_valid[1]), 32'd0);
    check("midrst/readData", readData[1], 32'd0);
    check("midrst/fault", 32'(fault[1]), 32'd0);
    reset[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("midrst/ready_after", 32'(req_ready[1]), 32'd1);
      seen = seen | resp_valid[1];
    end
    check("midrst/no_resp", 32'(seen), 32'd0);
    txn(1, 1'b0, 2'd0, 1'b1, 32'h50, 32'h0, 32'h0, 1'b0, "midrst/load");

    // Valid held high on the zero-latency instance: one accept per two cycles.
    @(negedge clk);
    req_write[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
    address[0] = 32'h10; req_valid[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 3) req_valid[0] = 1'b0;
      if (resp_valid[0] === 1'b1) pulses++;
    end
    check("thru/pulses", 32'(pulses), 32'd2);
    check("thru/readData", readData[0], 32'hDEADBEEF);

    for (int i = 0; i < 120; i++) begin
      int d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 32'hFFF8 + 32'($urandom_range(0, 7));
      else a = 32'h100 + 32'($urandom_range(0, 63));
      a = a | ($urandom & 32'hFFFF0000);
      mtxn(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
